// File: rtl/vlsu_pkg.sv
// ============================================================================
// Module : vlsu_pkg
// Brief  : Shared types for the metaInfo dispatcher.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vlsu_pkg;

   typedef logic [7:0] meta_glb_t;

   typedef enum logic {
      REQ_LD = 1'b0,
      REQ_ST = 1'b1
   } req_src_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FORK = 1'b1
   } disp_state_e;

endpackage

`default_nettype wire

// File: rtl/meta_info_dispatcher_if.sv
// ============================================================================
// Module : meta_info_dispatcher_if
// Brief  : Requester, consumer and credit signals of the metaInfo dispatcher.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface meta_info_dispatcher_if
   import vlsu_pkg::*;
#(
   parameter type meta_glb_t = vlsu_pkg::meta_glb_t
) ();

   logic      ld_valid_i;
   logic      ld_ready_o;
   meta_glb_t ld_meta_i;
   logic      st_valid_i;
   logic      st_ready_o;
   meta_glb_t st_meta_i;
   logic      seq_valid_o;
   logic      seq_ready_i;
   meta_glb_t seq_o;
   logic      shf_valid_o;
   logic      shf_ready_i;
   meta_glb_t shf_o;
   logic      done_i;
   logic      busy_o;
   logic      src_is_st_o;

   modport slave (
      input  ld_valid_i, ld_meta_i, st_valid_i, st_meta_i,
      input  seq_ready_i, shf_ready_i, done_i,
      output ld_ready_o, st_ready_o, seq_valid_o, seq_o,
      output shf_valid_o, shf_o, busy_o, src_is_st_o
   );

   modport master (
      output ld_valid_i, ld_meta_i, st_valid_i, st_meta_i,
      output seq_ready_i, shf_ready_i, done_i,
      input  ld_ready_o, st_ready_o, seq_valid_o, seq_o,
      input  shf_valid_o, shf_o, busy_o, src_is_st_o
   );

endinterface

`default_nettype wire

// File: rtl/meta_info_dispatcher_rr_arb2.sv
// ============================================================================
// Module : meta_rr_arb2
// Brief  : Two-requester round-robin arbiter with enable and last-grant reg.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module meta_rr_arb2
   import vlsu_pkg::*;
(
   input  wire logic       clk_i,
   input  wire logic       rst_i,
   input  wire logic       en_i,
   input  wire logic [1:0] req_i,
   output      logic [1:0] gnt_o
);

   req_src_e last_q, last_d;

   always_comb begin
      gnt_o  = 2'b00;
      last_d = last_q;
      if (en_i) begin
         // On a tie the requester that did not win last time goes first.
         if (req_i[0] && req_i[1]) begin
            gnt_o = (last_q == REQ_ST) ? 2'b01 : 2'b10;
         end else begin
            gnt_o = req_i;
         end
      end
      if (gnt_o[1]) begin
         last_d = REQ_ST;
      end else if (gnt_o[0]) begin
         last_d = REQ_LD;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= REQ_ST;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/meta_info_dispatcher.sv
// ============================================================================
// Module : meta_info_dispatcher
// Brief  : Arbitrates load/store metaInfo, forks it to seq/shf, bounds credits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module meta_info_dispatcher
   import vlsu_pkg::*;
#(
   parameter type         meta_glb_t     = vlsu_pkg::meta_glb_t,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
   input wire logic              clk_i,
   input wire logic              rst_i,
   meta_info_dispatcher_if.slave bus
);

   localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

   disp_state_e         state_q, state_d;
   logic                seq_pend_q, seq_pend_d;
   logic                shf_pend_q, shf_pend_d;
   meta_glb_t           meta_q, meta_d;
   req_src_e            src_q, src_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                done_underflow_q;

   logic       can_accept;
   logic       grant;
   logic       dec_ok;
   logic [1:0] gnt;

   meta_rr_arb2 u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (can_accept),
      .req_i ({bus.st_valid_i, bus.ld_valid_i}),
      .gnt_o (gnt)
   );

   always_comb begin
      // A new request may enter while the fork drains in this same cycle.
      can_accept = (cnt_q < MaxCnt) &&
                   ((state_q == ST_IDLE) ||
                    ((!seq_pend_q || bus.seq_ready_i) && (!shf_pend_q || bus.shf_ready_i)));
      grant      = |gnt;
      seq_pend_d = seq_pend_q && !bus.seq_ready_i;
      shf_pend_d = shf_pend_q && !bus.shf_ready_i;
      meta_d     = meta_q;
      src_d      = src_q;
      if (grant) begin
         seq_pend_d = 1'b1;
         shf_pend_d = 1'b1;
         meta_d     = gnt[1] ? bus.st_meta_i : bus.ld_meta_i;
         src_d      = gnt[1] ? REQ_ST : REQ_LD;
      end
      state_d = (seq_pend_d || shf_pend_d) ? ST_FORK : ST_IDLE;
   end

   always_comb begin
      dec_ok = bus.done_i && (cnt_q != '0);
      cnt_d  = cnt_q;
      case ({grant, dec_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q          <= ST_IDLE;
         seq_pend_q       <= 1'b0;
         shf_pend_q       <= 1'b0;
         meta_q           <= '0;
         src_q            <= REQ_LD;
         cnt_q            <= '0;
         done_underflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         seq_pend_q <= seq_pend_d;
         shf_pend_q <= shf_pend_d;
         meta_q     <= meta_d;
         src_q      <= src_d;
         cnt_q      <= cnt_d;
         // Sticky marker for a completion that arrived with no credit out.
         if (bus.done_i && (cnt_q == '0)) begin
            done_underflow_q <= 1'b1;
         end
      end
   end

   assign bus.ld_ready_o  = gnt[0];
   assign bus.st_ready_o  = gnt[1];
   assign bus.seq_valid_o = seq_pend_q;
   assign bus.shf_valid_o = shf_pend_q;
   assign bus.seq_o       = meta_q;
   assign bus.shf_o       = meta_q;
   assign bus.src_is_st_o = (src_q == REQ_ST);
   assign bus.busy_o      = (cnt_q != '0) || seq_pend_q || shf_pend_q;

endmodule

`default_nettype wire

// File: tb/tb_meta_info_dispatcher.sv
// ============================================================================
// Module : tb_meta_info_dispatcher
// Brief  : Directed self-checking bench for meta_info_dispatcher.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_meta_info_dispatcher;
   import vlsu_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   meta_info_dispatcher_if #(.meta_glb_t(meta_glb_t)) bus ();

   meta_info_dispatcher #(
      .meta_glb_t     (meta_glb_t),
      .MaxOutstanding (4)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.ld_valid_i  = 1'b0;
      bus.ld_meta_i   = '0;
      bus.st_valid_i  = 1'b0;
      bus.st_meta_i   = '0;
      bus.seq_ready_i = 1'b0;
      bus.shf_ready_i = 1'b0;
      bus.done_i      = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_seq_valid", bus.seq_valid_o, 0);
      check("rst_shf_valid", bus.shf_valid_o, 0);
      check("rst_busy",      bus.busy_o,      0);
      check("rst_src",       bus.src_is_st_o, 0);
      check("rst_meta",      bus.seq_o,       0);
      check("rst_cnt",       dut.cnt_q,       0);

      // Single load, both consumers ready
      bus.ld_valid_i  = 1'b1;
      bus.ld_meta_i   = 8'hA5;
      bus.seq_ready_i = 1'b1;
      bus.shf_ready_i = 1'b1;
      #1;
      check("t1_ld_ready", bus.ld_ready_o, 1);
      check("t1_st_ready", bus.st_ready_o, 0);
      tick();
      bus.ld_valid_i = 1'b0;
      #1;
      check("t1_seq_valid", bus.seq_valid_o, 1);
      check("t1_shf_valid", bus.shf_valid_o, 1);
      check("t1_seq_o",     bus.seq_o,       8'hA5);
      check("t1_shf_o",     bus.shf_o,       8'hA5);
      check("t1_cnt",       dut.cnt_q,       1);
      tick();
      check("t1_seq_clr", bus.seq_valid_o, 0);
      check("t1_shf_clr", bus.shf_valid_o, 0);
      check("t1_cnt2",    dut.cnt_q,       1);
      check("t1_busy",    bus.busy_o,      1);
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      #1;
      check("t1_cnt_done", dut.cnt_q, 0);
      check("t1_idle",     bus.busy_o, 0);

      // Skewed consumers: shuffle side stalls
      bus.shf_ready_i = 1'b0;
      bus.st_valid_i  = 1'b1;
      bus.st_meta_i   = 8'h3C;
      #1;
      check("t2_st_ready", bus.st_ready_o, 1);
      tick();
      bus.st_meta_i = 8'h5A;
      #1;
      check("t2_seq_valid", bus.seq_valid_o, 1);
      check("t2_shf_valid", bus.shf_valid_o, 1);
      check("t2_src",       bus.src_is_st_o, 1);
      check("t2_no_grant",  bus.st_ready_o,  0);
      tick();
      check("t2_seq_done",  bus.seq_valid_o, 0);
      check("t2_shf_hold",  bus.shf_valid_o, 1);
      check("t2_no_grant2", bus.st_ready_o,  0);
      tick();
      check("t2_seq_stay0", bus.seq_valid_o, 0);
      check("t2_meta_hold", bus.seq_o,       8'h3C);
      tick();
      check("t2_shf_hold3", bus.shf_valid_o, 1);
      bus.shf_ready_i = 1'b1;
      #1;
      check("t2_grant_rel", bus.st_ready_o, 1);
      tick();
      bus.st_valid_i = 1'b0;
      #1;
      check("t2_meta2", bus.seq_o,       8'h5A);
      check("t2_both",  bus.shf_valid_o, 1);
      check("t2_cnt",   dut.cnt_q,       2);
      tick();
      check("t2_drain", bus.seq_valid_o | bus.shf_valid_o, 0);
      bus.done_i = 1'b1;
      tick();
      tick();
      bus.done_i = 1'b0;
      #1;
      check("t2_cnt0", dut.cnt_q, 0);

      // Contention: last grant was store, so load goes first
      bus.ld_valid_i = 1'b1;
      bus.ld_meta_i  = 8'h11;
      bus.st_valid_i = 1'b1;
      bus.st_meta_i  = 8'h22;
      #1;
      check("t3_g0_ld", bus.ld_ready_o, 1);
      check("t3_g0_st", bus.st_ready_o, 0);
      tick();
      check("t3_src0",  bus.src_is_st_o, 0);
      check("t3_meta0", bus.seq_o,       8'h11);
      check("t3_g1_st", bus.st_ready_o,  1);
      check("t3_g1_ld", bus.ld_ready_o,  0);
      tick();
      check("t3_src1",  bus.src_is_st_o, 1);
      check("t3_meta1", bus.seq_o,       8'h22);
      check("t3_g2_ld", bus.ld_ready_o,  1);
      tick();
      check("t3_src2",  bus.src_is_st_o, 0);
      check("t3_g3_st", bus.st_ready_o,  1);
      tick();
      check("t3_src3", bus.src_is_st_o, 1);
      check("t3_cnt4", dut.cnt_q,       4);

      // Credit limit: no same-cycle bypass from done_i
      bus.st_valid_i = 1'b0;
      bus.done_i     = 1'b1;
      #1;
      check("t4_stall_ld", bus.ld_ready_o, 0);
      check("t4_stall_st", bus.st_ready_o, 0);
      tick();
      bus.done_i = 1'b0;
      #1;
      check("t4_cnt3",    dut.cnt_q,       3);
      check("t4_ld_rel",  bus.ld_ready_o,  1);
      check("t4_fork_dn", bus.seq_valid_o, 0);
      tick();
      bus.ld_valid_i = 1'b0;
      #1;
      check("t4_cnt4b", dut.cnt_q,       4);
      check("t4_src",   bus.src_is_st_o, 0);
      tick();

      // Simultaneous grant and done at cnt == 2, then done at cnt == 0
      bus.done_i = 1'b1;
      tick();
      tick();
      bus.done_i = 1'b0;
      #1;
      check("t5_cnt2", dut.cnt_q, 2);
      bus.ld_valid_i = 1'b1;
      bus.ld_meta_i  = 8'h77;
      bus.done_i     = 1'b1;
      #1;
      check("t5_ld_ready", bus.ld_ready_o, 1);
      tick();
      bus.ld_valid_i = 1'b0;
      bus.done_i     = 1'b0;
      #1;
      check("t5_cnt_same", dut.cnt_q, 2);
      check("t5_meta",     bus.seq_o, 8'h77);
      bus.done_i = 1'b1;
      tick();
      tick();
      bus.done_i = 1'b0;
      #1;
      check("t5_cnt0",  dut.cnt_q,            0);
      check("t5_uflow", dut.done_underflow_q, 0);
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      #1;
      check("t5_cnt0_ign", dut.cnt_q,            0);
      check("t5_uflow_on", dut.done_underflow_q, 1);

      // Reset mid-fork with three credits out and shuffle pending
      bus.ld_valid_i = 1'b1;
      tick();
      tick();
      bus.ld_valid_i = 1'b0;
      tick();
      bus.shf_ready_i = 1'b0;
      bus.ld_valid_i  = 1'b1;
      tick();
      bus.ld_valid_i = 1'b0;
      tick();
      check("t6_pre_cnt", dut.cnt_q,       3);
      check("t6_pre_shf", bus.shf_valid_o, 1);
      check("t6_pre_seq", bus.seq_valid_o, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.ld_valid_i  = 1'b1;
      bus.st_valid_i  = 1'b1;
      bus.shf_ready_i = 1'b1;
      #1;
      check("t6_shf",   bus.shf_valid_o,      0);
      check("t6_seq",   bus.seq_valid_o,      0);
      check("t6_cnt",   dut.cnt_q,            0);
      check("t6_state", dut.state_q,          ST_IDLE);
      check("t6_uflow", dut.done_underflow_q, 0);
      check("t6_ld_w",  bus.ld_ready_o,       1);
      check("t6_st_l",  bus.st_ready_o,       0);
      tick();
      bus.ld_valid_i = 1'b0;
      bus.st_valid_i = 1'b0;
      #1;
      check("t6_src", bus.src_is_st_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
